// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the pipelined ALU.
// Also holds the sign-rule overflow helper used by the add/subtract paths.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SUB  = 4'd0,
        OP_ADD  = 4'd1,
        OP_OR   = 4'd2,
        OP_AND  = 4'd3,
        OP_DEC  = 4'd4,
        OP_INC  = 4'd5,
        OP_NOTA = 4'd6,
        OP_NOTB = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MUL  = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    localparam int unsigned OPW = 4;

    // Signed overflow of s = a + b, judged on sign bits only.
    function automatic logic sgn_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The master side issues beats and consumes results; the slave side is the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUCtrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Overflow;
    logic             Zero;
    logic             Illegal;
    logic             ovf_sticky;
    logic             clr_sticky;

    modport master (
        output in_valid, A, B, ALUCtrl, out_ready, clr_sticky,
        input  in_ready, out_valid, S, Overflow, Zero, Illegal, ovf_sticky
    );

    modport slave (
        input  in_valid, A, B, ALUCtrl, out_ready, clr_sticky,
        output in_ready, out_valid, S, Overflow, Zero, Illegal, ovf_sticky
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier, one partial product per cycle.
// product_o carries the final sum combinationally during the cycle done_o is high.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = CW'(WIDTH - 1);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = acc_step;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops register in one cycle, MUL runs on alu_mul_seq.
// Owns the valid/ready protocol, result/flag registers and the sticky overflow bit.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic               zero_q;
    logic               sticky_q, sticky_d;
    logic               load;

    op_e                op;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   alu_s;
    logic               alu_ovf;
    logic               alu_ill;
    logic [SHW-1:0]     shamt;

    assign op        = op_e'(bus.ALUCtrl);
    assign shamt     = bus.B[SHW-1:0];
    assign bus.in_ready = !mul_busy &&
                          ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );

    always_comb begin
        alu_s   = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_SUB: begin
                alu_s   = bus.A - bus.B;
                alu_ovf = sgn_ovf(bus.A[WIDTH-1], ~bus.B[WIDTH-1], alu_s[WIDTH-1]);
            end
            OP_ADD: begin
                alu_s   = bus.A + bus.B;
                alu_ovf = sgn_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], alu_s[WIDTH-1]);
            end
            OP_OR:   alu_s = bus.A | bus.B;
            OP_AND:  alu_s = bus.A & bus.B;
            OP_DEC: begin
                alu_s   = bus.A - 1'b1;
                alu_ovf = sgn_ovf(bus.A[WIDTH-1], 1'b1, alu_s[WIDTH-1]);
            end
            OP_INC: begin
                alu_s   = bus.A + 1'b1;
                alu_ovf = sgn_ovf(bus.A[WIDTH-1], 1'b0, alu_s[WIDTH-1]);
            end
            OP_NOTA: alu_s = ~bus.A;
            OP_NOTB: alu_s = ~bus.B;
            OP_SLL:  alu_s = bus.A << shamt;
            OP_SRL:  alu_s = bus.A >> shamt;
            OP_SRA:  alu_s = $signed(bus.A) >>> shamt;
            OP_MUL:  alu_s = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // A new beat can only be accepted from IDLE or a draining DONE, so it is
    // handled once after the per-state transitions and overrides them.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        load    = 1'b0;
        case (state_q)
            IDLE: ;
            EXEC: begin
                if (mul_done) begin
                    state_d = DONE;
                    s_d     = mul_prod[WIDTH-1:0];
                    ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
                    ill_d   = 1'b0;
                    load    = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (op == OP_MUL) begin
                state_d = EXEC;
            end else begin
                state_d = DONE;
                s_d     = alu_s;
                ovf_d   = alu_ovf;
                ill_d   = alu_ill;
                load    = 1'b1;
            end
        end
        sticky_d = (load && ovf_d) || (sticky_q && !bus.clr_sticky);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            zero_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            sticky_q <= sticky_d;
            if (load) zero_q <= (s_d == '0);
        end
    end

    assign bus.out_valid  = (state_q == DONE);
    assign bus.S          = s_q;
    assign bus.Overflow   = ovf_q;
    assign bus.Zero       = zero_q;
    assign bus.Illegal    = ill_q;
    assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe with hand-computed expected results.
// Covers single-cycle ops, multiply latency, backpressure, illegal opcodes and mid-multiply reset.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] s, input logic ovf,
                                input logic zero, input logic ill);
        check_eq({tag, ".S"},        32'(bus.S),        32'(s));
        check_eq({tag, ".Overflow"}, 32'(bus.Overflow), 32'(ovf));
        check_eq({tag, ".Zero"},     32'(bus.Zero),     32'(zero));
        check_eq({tag, ".Illegal"},  32'(bus.Illegal),  32'(ill));
        check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic        took;
        int unsigned n;
        bus.in_valid = 1'b1;
        bus.ALUCtrl  = op;
        bus.A        = a;
        bus.B        = b;
        took = 1'b0;
        n    = 0;
        while (!took && n < 50) begin
            took = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check_eq("accept", 32'(took), 32'd1);
    endtask

    task automatic wait_result(output int unsigned lat, output int unsigned low);
        lat = 0;
        low = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready === 1'b0) low++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat, low;

        vecs[0] = '{OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
        vecs[1] = '{OP_SRA,  16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0};
        vecs[2] = '{OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b0};
        vecs[3] = '{OP_SLL,  16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0};
        vecs[4] = '{OP_SRL,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{OP_NOTB, 16'h0000, 16'h00FF, 16'hFF00, 1'b0, 1'b0};
        vecs[6] = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        vecs[7] = '{OP_NOTA, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1};

        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.ALUCtrl    = '0;
        bus.out_ready  = 1'b1;
        bus.clr_sticky = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check_eq("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst.S",         32'(bus.S),         32'd0);
        check_eq("rst.Overflow",  32'(bus.Overflow),  32'd0);
        check_eq("rst.Zero",      32'(bus.Zero),      32'd0);
        check_eq("rst.Illegal",   32'(bus.Illegal),   32'd0);
        check_eq("rst.sticky",    32'(bus.ovf_sticky), 32'd0);
        check_eq("rst.in_ready",  32'(bus.in_ready),  32'd1);

        send(OP_ADD, 16'h7FFF, 16'h0001);
        check_result("add_ovf", 16'h8000, 1'b1, 1'b0, 1'b0);
        check_eq("add_ovf.sticky", 32'(bus.ovf_sticky), 32'd1);
        bus.clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_sticky = 1'b0;
        check_eq("clr.sticky",    32'(bus.ovf_sticky), 32'd0);
        check_eq("clr.out_valid", 32'(bus.out_valid),  32'd0);

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].ovf, vecs[i].zero, 1'b0);
        end
        check_eq("dec.sticky", 32'(bus.ovf_sticky), 32'd1);

        bus.clr_sticky = 1'b1;
        send(OP_MUL, 16'h0100, 16'h0100);
        bus.clr_sticky = 1'b0;
        wait_result(lat, low);
        check_eq("mul_big.latency",  lat, 32'd16);
        check_eq("mul_big.ready_lo", low, 32'd16);
        check_result("mul_big", 16'h0000, 1'b1, 1'b1, 1'b0);
        check_eq("mul_big.sticky", 32'(bus.ovf_sticky), 32'd1);

        send(OP_MUL, 16'h0003, 16'h0007);
        wait_result(lat, low);
        check_eq("mul_small.latency", lat, 32'd16);
        check_result("mul_small", 16'h0015, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(OP_INC, 16'hFFFF, 16'h0000);
        check_result("bp", 16'h0000, 1'b0, 1'b1, 1'b0);
        check_eq("bp.in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_result($sformatf("bp_hold%0d", k), 16'h0000, 1'b0, 1'b1, 1'b0);
            check_eq("bp_hold.in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ALUCtrl   = OP_OR;
        bus.A         = 16'h00F0;
        bus.B         = 16'h0F00;
        #1;
        check_eq("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_result("no_bubble", 16'h0FF0, 1'b0, 1'b0, 1'b0);

        send(4'd13, 16'h1234, 16'h0000);
        check_result("illegal", 16'h0000, 1'b0, 1'b1, 1'b1);

        send(OP_MUL, 16'h0003, 16'h0007);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_mul.in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("mid_mul.sticky",   32'(bus.ovf_sticky), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst.out_valid", 32'(bus.out_valid),  32'd0);
        check_eq("async_rst.S",         32'(bus.S),          32'd0);
        check_eq("async_rst.Overflow",  32'(bus.Overflow),   32'd0);
        check_eq("async_rst.Zero",      32'(bus.Zero),       32'd0);
        check_eq("async_rst.Illegal",   32'(bus.Illegal),    32'd0);
        check_eq("async_rst.sticky",    32'(bus.ovf_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst.in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("post_rst.out_valid", 32'(bus.out_valid), 32'd0);
        send(OP_ADD, 16'h0002, 16'h0003);
        check_result("post_rst_add", 16'h0005, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("no_stale_mul.out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
